// File: rtl/quad_gen_pkg.sv
// Shared phase encoding and helper functions for the quadrature generator.
// The phase register holds {A,B} directly, so the Gray sequence needs no decode.
package quad_gen_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // dir = 1 walks 00->01->11->10; dir = 0 walks the same ring backwards.
  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic dir);
    logic [1:0] np;
    case (ph)
      PH_00:   np = dir ? PH_01 : PH_10;
      PH_01:   np = dir ? PH_11 : PH_00;
      PH_11:   np = dir ? PH_10 : PH_01;
      default: np = dir ? PH_00 : PH_11;
    endcase
    return np;
  endfunction

  function automatic logic [1:0] phase_to_ab(input logic [1:0] ph);
    return ph;
  endfunction

endpackage

// File: rtl/quad_gen_dds.sv
// Rate-magnitude DDS accumulator: emits a one-cycle step (combinational carry)
// and the step direction taken from the rate sign.
module quad_gen_dds #(
  parameter int W     = 14,
  parameter int ACC_W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] rate,
  output logic         step,
  output logic         dir
);

  logic [W-1:0]     mag;
  logic [ACC_W-1:0] mag_ext;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W:0]   sum;

  // The most negative rate maps to 2^(W-1), which still fits W unsigned bits.
  always_comb begin
    mag     = rate[W-1] ? (-rate) : rate;
    mag_ext = ACC_W'(mag);
    sum     = {1'b0, acc_reg} + {1'b0, mag_ext};
    step    = en & sum[ACC_W];
    dir     = ~rate[W-1];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/quad_gen.sv
// Quadrature encoder emulator: DDS steps feed a dwell-limited Gray sequencer.
// Define QUAD_GEN_INDEX_EN to build the position counter and Z index output.
module quad_gen
  import quad_gen_pkg::*;
#(
  parameter int W         = 14,
  parameter int ACC_W     = 20,
  parameter int CPR       = 2000,
  parameter int MIN_DWELL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] rate,
  input  logic         clr,
  input  logic         ovr_clr,
  output logic         A,
  output logic         B,
  output logic         Z,
  output logic         overrun
);

  localparam int DWELL_W = $clog2(MIN_DWELL);

  logic               step;
  logic               step_dir;
  logic               pending_reg;
  logic               pdir_reg;
  logic [DWELL_W-1:0] dwell_reg;
  logic [1:0]         phase_reg;
  logic               overrun_reg;
  logic               cancel;
  logic               drop;
  logic               edge_fire;

  quad_gen_dds #(.W(W), .ACC_W(ACC_W)) u_dds (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (en),
    .rate (rate),
    .step (step),
    .dir  (step_dir)
  );

  // An opposite step while one is pending nets to zero and suppresses the edge.
  always_comb begin
    cancel    = step & pending_reg & (step_dir != pdir_reg);
    drop      = step & pending_reg & (step_dir == pdir_reg);
    edge_fire = pending_reg & (dwell_reg == '0) & ~cancel;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pending_reg <= 1'b0;
      pdir_reg    <= 1'b0;
      dwell_reg   <= '0;
      phase_reg   <= PH_00;
    end else begin
      if (cancel || edge_fire) begin
        pending_reg <= 1'b0;
      end else if (step && !pending_reg) begin
        pending_reg <= 1'b1;
        pdir_reg    <= step_dir;
      end
      if (edge_fire) begin
        phase_reg <= next_phase(phase_reg, pdir_reg);
        dwell_reg <= DWELL_W'(MIN_DWELL - 1);
      end else if (dwell_reg != '0) begin
        dwell_reg <= dwell_reg - DWELL_W'(1);
      end
    end
  end

  // A new drop beats a simultaneous clear request; clr leaves the flag alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_reg <= 1'b0;
    end else if (drop && !clr) begin
      overrun_reg <= 1'b1;
    end else if (ovr_clr) begin
      overrun_reg <= 1'b0;
    end
  end

  assign {A, B}  = phase_to_ab(phase_reg);
  assign overrun = overrun_reg;

`ifdef QUAD_GEN_INDEX_EN
  localparam int POS_W = $clog2(CPR);

  logic [POS_W-1:0] pos_reg;
  logic [POS_W-1:0] pos_next;
  logic             z_reg;

  always_comb begin
    pos_next = pos_reg;
    if (edge_fire) begin
      if (pdir_reg) begin
        pos_next = (pos_reg == POS_W'(CPR - 1)) ? '0 : pos_reg + POS_W'(1);
      end else begin
        pos_next = (pos_reg == '0) ? POS_W'(CPR - 1) : pos_reg - POS_W'(1);
      end
    end
  end

  // Z is registered from the next position so it lines up with the A/B edge.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pos_reg <= '0;
      z_reg   <= 1'b1;
    end else begin
      pos_reg <= pos_next;
      z_reg   <= (pos_next == '0);
    end
  end

  assign Z = z_reg;
`else
  logic cpr_unused;
  assign cpr_unused = (CPR % 4) != 0;
  assign Z = 1'b0;
`endif

endmodule

// File: tb/tb_quad_gen.sv
// Scoreboard bench for quad_gen: a fast instance (MIN_DWELL=4) and a slow one
// (MIN_DWELL=200) share stimulus; Z expectations follow QUAD_GEN_INDEX_EN.
module tb_quad_gen;

  localparam int W     = 18;
  localparam int ACC_W = 20;
  localparam int CPR   = 2000;

`ifdef QUAD_GEN_INDEX_EN
  localparam logic IDX = 1'b1;
`else
  localparam logic IDX = 1'b0;
`endif

  typedef struct {
    logic [1:0] ab;
    logic       z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, en, clr, ovr_clr;
  logic [W-1:0] rate;
  logic         A, B, Z, overrun;
  logic         As, Bs, Zs, overrun_s;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  quad_gen #(.W(W), .ACC_W(ACC_W), .CPR(CPR), .MIN_DWELL(4)) dut (
    .clk(clk), .rst(rst), .en(en), .rate(rate), .clr(clr), .ovr_clr(ovr_clr),
    .A(A), .B(B), .Z(Z), .overrun(overrun)
  );

  quad_gen #(.W(W), .ACC_W(ACC_W), .CPR(CPR), .MIN_DWELL(200)) dut_s (
    .clk(clk), .rst(rst), .en(en), .rate(rate), .clr(clr), .ovr_clr(ovr_clr),
    .A(As), .B(Bs), .Z(Zs), .overrun(overrun_s)
  );

  // Gray code of a position: index pos mod 4 into 00,01,11,10.
  function automatic logic [1:0] ab_of(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; ovr_clr = 1'b0; rate = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int edges;
    logic [1:0] prev;
    do_reset();
    en = 1'b1; rate = '0;
    edges = 0; prev = {A, B};
    repeat (100) begin
      @(negedge clk);
      if ({A, B} !== prev) edges++;
      prev = {A, B};
    end
    vectors++; if (edges != 0) begin miscompares++; $display("FAIL reset_edges: got %0d want 0", edges); end
    vectors++; if ({A, B} !== 2'b00) begin miscompares++; $display("FAIL reset_ab: got %b want 00", {A, B}); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    vectors++; if (Z !== IDX) begin miscompares++; $display("FAIL reset_z: got %b want %b", Z, IDX); end
    vectors++; if (overrun_s !== 1'b0) begin miscompares++; $display("FAIL reset_ovr_s: got %b want 0", overrun_s); end
    $display("reset: %0d edges in 100 clk, AB=%b Z=%b", edges, {A, B}, Z);
  endtask

  task automatic test_forward();
    int pos, cyc, last;
    logic [1:0] prev;
    exp_t e;
    do_reset();
    pos = 0;
    for (int i = 0; i < 8; i++) begin
      pos = (pos + 1) % CPR;
      exp_q.push_back('{ab: ab_of(pos), z: IDX && (pos == 0)});
    end
    en = 1'b1; rate = 18'h04000;
    cyc = 0; last = -1; prev = {A, B};
    while (exp_q.size() > 0 && cyc < 2000) begin
      @(negedge clk); cyc++;
      if ({A, B} !== prev) begin
        e = exp_q.pop_front();
        vectors++; if ({A, B} !== e.ab) begin miscompares++; $display("FAIL fwd_ab: got %b want %b", {A, B}, e.ab); end
        vectors++; if (Z !== e.z) begin miscompares++; $display("FAIL fwd_z: got %b want %b", Z, e.z); end
        if (last >= 0) begin
          vectors++; if (cyc - last != 64) begin miscompares++; $display("FAIL fwd_period: got %0d want 64", cyc - last); end
        end
        $display("fwd edge at clk %0d: AB=%b Z=%b", cyc, {A, B}, Z);
        last = cyc; prev = {A, B};
      end
    end
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL fwd_timeout: got %0d edges outstanding want 0", exp_q.size());
      exp_q.delete();
    end
    // A synchronous clear mid-stream returns to the home phase.
    rate = '0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    vectors++; if ({A, B} !== 2'b00) begin miscompares++; $display("FAIL clr_ab: got %b want 00", {A, B}); end
    vectors++; if (Z !== IDX) begin miscompares++; $display("FAIL clr_z: got %b want %b", Z, IDX); end
  endtask

  task automatic test_reverse();
    int pos, cyc, last;
    logic [1:0] prev;
    exp_t e;
    do_reset();
    pos = 0;
    for (int i = 0; i < 6; i++) begin
      pos = (pos + CPR - 1) % CPR;
      exp_q.push_back('{ab: ab_of(pos), z: IDX && (pos == 0)});
    end
    en = 1'b1; rate = 18'h3E000;
    cyc = 0; last = -1; prev = {A, B};
    while (exp_q.size() > 0 && cyc < 2000) begin
      @(negedge clk); cyc++;
      if ({A, B} !== prev) begin
        e = exp_q.pop_front();
        vectors++; if ({A, B} !== e.ab) begin miscompares++; $display("FAIL rev_ab: got %b want %b", {A, B}, e.ab); end
        vectors++; if (Z !== e.z) begin miscompares++; $display("FAIL rev_z: got %b want %b", Z, e.z); end
        if (last >= 0) begin
          vectors++; if (cyc - last != 128) begin miscompares++; $display("FAIL rev_period: got %0d want 128", cyc - last); end
        end
        $display("rev edge at clk %0d: AB=%b Z=%b", cyc, {A, B}, Z);
        last = cyc; prev = {A, B};
      end
    end
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL rev_timeout: got %0d edges outstanding want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_cancel();
    int chg_f, chg_s;
    logic [1:0] prev_f, prev_s;
    do_reset();
    chg_f = 0; chg_s = 0; prev_f = {A, B}; prev_s = {As, Bs};
    en = 1'b1; rate = 18'h04000;
    for (int c = 0; c < 460; c++) begin
      if (c == 150) rate = 18'h3C000;
      if (c == 210) rate = '0;
      @(negedge clk);
      if ({A, B} !== prev_f) chg_f++;
      if ({As, Bs} !== prev_s) chg_s++;
      prev_f = {A, B}; prev_s = {As, Bs};
    end
    vectors++; if (chg_s != 1) begin miscompares++; $display("FAIL cancel_slow_edges: got %0d want 1", chg_s); end
    vectors++; if ({As, Bs} !== 2'b01) begin miscompares++; $display("FAIL cancel_slow_ab: got %b want 01", {As, Bs}); end
    vectors++; if (overrun_s !== 1'b0) begin miscompares++; $display("FAIL cancel_slow_ovr: got %b want 0", overrun_s); end
    vectors++; if (chg_f != 3) begin miscompares++; $display("FAIL cancel_fast_edges: got %0d want 3", chg_f); end
    vectors++; if ({A, B} !== 2'b01) begin miscompares++; $display("FAIL cancel_fast_ab: got %b want 01", {A, B}); end
    $display("cancel: slow edges %0d, fast edges %0d", chg_s, chg_f);
  endtask

  task automatic test_overrun();
    logic seen_s, seen_f;
    do_reset();
    en = 1'b1; rate = 18'h02000;
    repeat (1000) @(negedge clk);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_fast: got %b want 0", overrun); end
    vectors++; if (overrun_s !== 1'b1) begin miscompares++; $display("FAIL ovr_slow: got %b want 1", overrun_s); end
    rate = '0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    vectors++; if (overrun_s !== 1'b1) begin miscompares++; $display("FAIL ovr_clr_keeps: got %b want 1", overrun_s); end
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    vectors++; if (overrun_s !== 1'b0) begin miscompares++; $display("FAIL ovr_cleared: got %b want 0", overrun_s); end
    // Hold ovr_clr: a drop must still surface for the cycle it happens.
    seen_s = 1'b0; seen_f = 1'b0;
    rate = 18'h02000; ovr_clr = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (overrun_s === 1'b1) seen_s = 1'b1;
      if (overrun === 1'b1) seen_f = 1'b1;
    end
    ovr_clr = 1'b0; rate = '0;
    vectors++; if (seen_s !== 1'b1) begin miscompares++; $display("FAIL ovr_set_wins: got %b want 1", seen_s); end
    vectors++; if (seen_f !== 1'b0) begin miscompares++; $display("FAIL ovr_fast_held: got %b want 0", seen_f); end
    $display("overrun: slow set-wins observed=%b", seen_s);
  endtask

  task automatic test_index();
    int edges, cyc, count, z_high, z_rise, idx, nidx;
    logic [1:0] prev;
    logic prev_z, exp_z;
    do_reset();
    en = 1'b1; rate = 18'h10000;
    edges = 0; cyc = 0; count = 0; z_high = 0; z_rise = 0; idx = 0;
    prev = {A, B}; prev_z = Z;
    while (edges < CPR && cyc < 40000) begin
      @(negedge clk); cyc++;
      if (Z === 1'b1 && prev_z === 1'b0) z_rise++;
      prev_z = Z;
      if ({A, B} !== prev) begin
        edges++;
        nidx = -1;
        for (int k = 0; k < 4; k++) if (ab_of(k) === {A, B}) nidx = k;
        if (nidx == (idx + 1) % 4) count++;
        else if (nidx == (idx + 3) % 4) count--;
        idx = nidx;
        exp_z = IDX && (edges % CPR == 0);
        if (Z === 1'b1) z_high++;
        vectors++; if (Z !== exp_z) begin miscompares++; $display("FAIL idx_z edge %0d: got %b want %b", edges, Z, exp_z); end
        prev = {A, B};
      end
    end
    vectors++; if (count != CPR) begin miscompares++; $display("FAIL idx_count: got %0d want %0d", count, CPR); end
    vectors++; if (z_high != (IDX ? 1 : 0)) begin miscompares++; $display("FAIL idx_zhigh: got %0d want %0d", z_high, IDX ? 1 : 0); end
    vectors++; if (z_rise != (IDX ? 1 : 0)) begin miscompares++; $display("FAIL idx_latch: got %0d want %0d", z_rise, IDX ? 1 : 0); end
    vectors++; if ({A, B} !== 2'b00) begin miscompares++; $display("FAIL idx_ab: got %b want 00", {A, B}); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL idx_ovr: got %b want 0", overrun); end
    $display("index: %0d edges, decoder count %0d, index pulses %0d", edges, count, z_rise);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_cancel();
    test_overrun();
    test_index();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
